riscv_dcache_tag_nway: RTL
==========================

# riscv_dcache_tag_nway

Set-associative tag/valid/dirty store for the data cache, generalising the direct-mapped tag array to `WAYS` ways with tree pseudo-LRU replacement. It gives the cache FSM combinational hit, victim and dirty flags for the presented index. It also contains an optional flush walker that writes back every dirty line and invalidates the whole cache, used for fence/cache-maintenance operations. It sits between the dcache controller FSM and the data array, which is indexed by `{index, way}`.

## Interface
- `WAYS`, 4, number of ways; power of 2, at least 2
- `IDX`, 10, index width; number of sets is `SETS = 2**IDX`
- `TAG`, 11, tag width
- `WAY_W`, `$clog2(WAYS)`, way-select width (derived)
- `clk`  in  1  clock; all storage and FSM update on the negative edge
- `rst`  in  1  asynchronous, active-high reset
- `index`  in  IDX  set index for lookup, fill and dirty-mark
- `tag_in`  in  TAG  tag to compare, or tag to write on fill
- `valid_in`  in  1  valid bit written on fill
- `dirty_in`  in  1  dirty bit written on fill
- `replace_tag`  in  1  fill the victim way of `index` with `tag_in`/`valid_in`/`dirty_in`
- `set_dirty`  in  1  mark the hit way of `index` dirty (store hit)
- `access`  in  1  on a hit, promote the hit way to MRU
- `hit`  out  1  some valid way of `index` matches `tag_in`
- `hit_way`  out  WAY_W  matching way; 0 when no hit
- `victim_way`  out  WAY_W  way that `replace_tag` would fill
- `dirty`  out  1  valid and dirty bits of the victim way, ANDed
- `tag_old`  out  TAG  stored tag of the victim way
- `flush_req`  in  1  start a clean-and-invalidate walk
- `flush_busy`  out  1  walker active
- `flush_done`  out  1  one-cycle pulse when the walk completes
- `flush_wb_valid`  out  1  dirty line awaiting writeback
- `flush_wb_index`  out  IDX  set of the line to write back
- `flush_wb_way`  out  WAY_W  way of the line to write back
- `flush_wb_tag`  out  TAG  tag of the line to write back
- `flush_wb_ack`  in  1  controller has accepted the writeback

## Operation
- Lookup is fully combinational from `index` and `tag_in`. Multiple matching ways are illegal; if they occur, the lowest matching way is reported.
- Victim selection:
  - the lowest-numbered invalid way, if any
  - otherwise the way selected by the set's tree PLRU (`WAYS-1` bits per set)
- `replace_tag`: at the negedge, write tag/valid/dirty into `victim_way` and promote that way to MRU.
- `set_dirty` with `hit`: set dirty on `hit_way`. With no hit, nothing changes.
- `access` with `hit`: promote `hit_way` to MRU.
- If `replace_tag` and `set_dirty` are asserted together, the fill wins and `set_dirty` is ignored.
- Flush FSM states and transitions:
  - IDLE: on `flush_req`, go to SCAN with set pointer and way pointer at 0.
  - SCAN: examine one entry per cycle.
    - If the entry is valid and dirty, go to WB.
    - Otherwise clear its valid and dirty bits and advance the pointer, way first and then set.
    - After the last entry (set `SETS-1`, way `WAYS-1`), go to DONE.
  - WB: hold `flush_wb_valid` with the index/way/tag stable until `flush_wb_ack`. On ack, clear that entry's valid and dirty bits, advance the pointer, and return to SCAN (or go to DONE after the last entry).
  - DONE: pulse `flush_done` for one cycle, reset all PLRU bits to 0, return to IDLE.
- While `flush_busy`:
  - `hit` is forced to 0
  - `replace_tag`, `set_dirty` and `access` are ignored
  - a repeated `flush_req` is ignored
- `flush_req` in the same cycle as `replace_tag` in IDLE: the fill is performed, and the walk starts from entry 0 on the same edge.

## Timing
- Reset values: `hit`=0, `hit_way`=0, `victim_way`=0, `dirty`=0, `tag_old`=0, `flush_busy`=0, `flush_done`=0, `flush_wb_valid`=0. Reset also clears every tag, valid, dirty and PLRU bit.
- Lookup, victim and dirty outputs reflect array contents written at or before the previous negedge. There is no bypass of a write in the same cycle.
- Flush with no dirty lines takes `SETS*WAYS` cycles in SCAN plus 1 cycle in DONE.
- Each dirty line adds 1 cycle plus the cycles spent waiting for `flush_wb_ack`.
- `flush_wb_ack` is sampled only while `flush_wb_valid` is high.
- An `rst` assertion during a walk aborts it immediately to IDLE with all arrays cleared. No `flush_done` is produced.

## Configuration
- `RISCV_DCACHE_FLUSH_EN` defined: the walker is built as described above.
- `RISCV_DCACHE_FLUSH_EN` undefined:
  - the flush ports remain
  - `flush_busy`, `flush_done`, `flush_wb_valid` and the wb fields are tied to 0
  - `flush_req` and `flush_wb_ack` are ignored
  - lookup is never blocked

## Structure
- Package `riscv_dcache_pkg`: flush state enum (IDLE/SCAN/WB/DONE) and PLRU update/victim functions parameterised on `WAYS`.
- Sub-module `riscv_dcache_plru`: combinational per-set tree PLRU. Given the current bits and a promoted way, it produces the next bits; it also produces the victim way. This module is instantiated once.

## Test plan
- After reset, `index`=5, `tag_in`=0x12 → `hit`=0, `victim_way`=0, `dirty`=0, `tag_old`=0.
- Fill set 5 with tags 0x10, 0x11, 0x12, 0x13 (ways 0–3), then `access` a hit on tag 0x10 → `victim_way`=1 (PLRU), and `hit_way`=0 for tag 0x10.
- `set_dirty` on a hit to tag 0x11, set 5, then fill tag 0x20 when way 1 is the victim → before the fill, `dirty`=1 and `tag_old`=0x11.
- With the flush macro on, two dirty lines in sets 0 and 3, and `flush_wb_ack` delayed 2 cycles each → `flush_wb_valid` appears exactly twice with the correct index/way/tag. `flush_done` pulses at cycle `SETS*WAYS`+2×3+1. All lookups then miss.
- Assert `rst` mid-walk while in WB → outputs return to their reset values, no `flush_done` is produced, and all entries are invalid.
- `replace_tag` and `set_dirty` together on the same set → the fill's `dirty_in` is stored, and no other way changes.

Source files
------------

// File: rtl/riscv_dcache_pkg.sv
// Shared types and tree-PLRU helpers for the set-associative dcache tag store.
// Tree levels are rooted on way bit 0; a node bit names the side holding the victim.
package riscv_dcache_pkg;

  typedef enum logic [1:0] {
    FL_IDLE,
    FL_SCAN,
    FL_WB,
    FL_DONE
  } flush_state_e;

  localparam int unsigned PLRU_MAX_W = 5;

  // Follow the node bits from the root to the pseudo-LRU way.
  function automatic logic [7:0] plru_victim(input logic [31:0] bits,
                                             input int unsigned way_w);
    logic [7:0]  v;
    logic [31:0] node;
    v = '0;
    for (int unsigned l = 0; l < PLRU_MAX_W; l++) begin
      if (l < way_w) begin
        node = ((32'd1 << l) - 32'd1) + (32'(v) & ((32'd1 << l) - 32'd1));
        v[l[2:0]] = bits[node[4:0]];
      end
    end
    return v;
  endfunction

  // Point every node on the path of way away from it.
  function automatic logic [31:0] plru_update(input logic [31:0] bits,
                                              input logic [7:0]  way,
                                              input int unsigned way_w);
    logic [31:0] b;
    logic [31:0] node;
    b = bits;
    for (int unsigned l = 0; l < PLRU_MAX_W; l++) begin
      if (l < way_w) begin
        node = ((32'd1 << l) - 32'd1) + (32'(way) & ((32'd1 << l) - 32'd1));
        b[node[4:0]] = ~way[l[2:0]];
      end
    end
    return b;
  endfunction

endpackage

// File: rtl/riscv_dcache_tag_nway_plru.sv
// Combinational per-set tree PLRU: next bits for a promoted way, and the current victim.
module riscv_dcache_plru
  import riscv_dcache_pkg::*;
#(
  parameter int unsigned WAYS  = 4,
  parameter int unsigned WAY_W = $clog2(WAYS)
) (
  input  logic [WAYS-2:0]  bits_cur,
  input  logic [WAY_W-1:0] promote_way,
  output logic [WAYS-2:0]  bits_next,
  output logic [WAY_W-1:0] lru_way
);

  always_comb begin
    bits_next = (WAYS-1)'(plru_update(32'(bits_cur), 8'(promote_way), WAY_W));
    lru_way   = WAY_W'(plru_victim(32'(bits_cur), WAY_W));
  end

endmodule

// File: rtl/riscv_dcache_tag_nway.sv
// N-way tag/valid/dirty store with tree PLRU; arrays update on the falling clock edge.
// Optional clean-and-invalidate walker built when RISCV_DCACHE_FLUSH_EN is defined.
module riscv_dcache_tag_nway
  import riscv_dcache_pkg::*;
#(
  parameter int unsigned WAYS  = 4,
  parameter int unsigned IDX   = 10,
  parameter int unsigned TAG   = 11,
  parameter int unsigned WAY_W = $clog2(WAYS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX-1:0]   index,
  input  logic [TAG-1:0]   tag_in,
  input  logic             valid_in,
  input  logic             dirty_in,
  input  logic             replace_tag,
  input  logic             set_dirty,
  input  logic             access,
  output logic             hit,
  output logic [WAY_W-1:0] hit_way,
  output logic [WAY_W-1:0] victim_way,
  output logic             dirty,
  output logic [TAG-1:0]   tag_old,
  input  logic             flush_req,
  output logic             flush_busy,
  output logic             flush_done,
  output logic             flush_wb_valid,
  output logic [IDX-1:0]   flush_wb_index,
  output logic [WAY_W-1:0] flush_wb_way,
  output logic [TAG-1:0]   flush_wb_tag,
  input  logic             flush_wb_ack
);

  localparam int unsigned SETS  = 2**IDX;
  localparam int unsigned PTR_W = IDX + WAY_W;

  logic [TAG-1:0]  tag_mem   [SETS][WAYS];
  logic [WAYS-1:0] valid_mem [SETS];
  logic [WAYS-1:0] dirty_mem [SETS];
  logic [WAYS-2:0] plru_mem  [SETS];

  logic             blocked;
  logic             raw_hit;
  logic [WAY_W-1:0] raw_hit_way;
  logic             any_invalid;
  logic [WAY_W-1:0] inv_way;
  logic [WAY_W-1:0] lru_way;
  logic [WAY_W-1:0] promote_way;
  logic [WAYS-2:0]  plru_next;
  logic             fill_en;
  logic             mark_en;
  logic             promote_en;
  logic             clr_en;
  logic             plru_clr;
  logic [IDX-1:0]   fl_set;
  logic [WAY_W-1:0] fl_way;

  // Lowest matching way and lowest invalid way of the presented set.
  always_comb begin
    raw_hit     = 1'b0;
    raw_hit_way = '0;
    any_invalid = 1'b0;
    inv_way     = '0;
    for (int unsigned i = 0; i < WAYS; i++) begin
      if (!raw_hit && valid_mem[index][WAY_W'(i)] && (tag_mem[index][WAY_W'(i)] == tag_in)) begin
        raw_hit     = 1'b1;
        raw_hit_way = WAY_W'(i);
      end
      if (!any_invalid && !valid_mem[index][WAY_W'(i)]) begin
        any_invalid = 1'b1;
        inv_way     = WAY_W'(i);
      end
    end
  end

  assign hit        = raw_hit & ~blocked;
  assign hit_way    = hit ? raw_hit_way : '0;
  assign victim_way = any_invalid ? inv_way : lru_way;
  assign dirty      = valid_mem[index][victim_way] & dirty_mem[index][victim_way];
  assign tag_old    = tag_mem[index][victim_way];

  assign fill_en     = replace_tag & ~blocked;
  assign mark_en     = set_dirty & hit & ~replace_tag;
  assign promote_en  = fill_en | (access & hit);
  assign promote_way = replace_tag ? victim_way : raw_hit_way;

  riscv_dcache_plru #(
    .WAYS  (WAYS),
    .WAY_W (WAY_W)
  ) u_plru (
    .bits_cur    (plru_mem[index]),
    .promote_way (promote_way),
    .bits_next   (plru_next),
    .lru_way     (lru_way)
  );

`ifdef RISCV_DCACHE_FLUSH_EN
  flush_state_e     state, state_nx;
  logic [PTR_W-1:0] ptr, ptr_nx;
  logic             ptr_last;
  logic             entry_dirty;

  assign fl_set      = ptr[PTR_W-1:WAY_W];
  assign fl_way      = ptr[WAY_W-1:0];
  assign ptr_last    = &ptr;
  assign entry_dirty = valid_mem[fl_set][fl_way] & dirty_mem[fl_set][fl_way];

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state <= FL_IDLE;
      ptr   <= '0;
    end else begin
      state <= state_nx;
      ptr   <= ptr_nx;
    end
  end

  // Walk one entry per cycle, pausing in WB for each dirty line.
  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    clr_en   = 1'b0;
    plru_clr = 1'b0;
    case (state)
      FL_IDLE: begin
        if (flush_req) begin
          state_nx = FL_SCAN;
          ptr_nx   = '0;
        end
      end
      FL_SCAN: begin
        if (entry_dirty) begin
          state_nx = FL_WB;
        end else begin
          clr_en = 1'b1;
          if (ptr_last) state_nx = FL_DONE;
          else          ptr_nx   = ptr + PTR_W'(1);
        end
      end
      FL_WB: begin
        if (flush_wb_ack) begin
          clr_en = 1'b1;
          if (ptr_last) state_nx = FL_SCAN == FL_SCAN ? FL_DONE : FL_DONE;
          else begin
            state_nx = FL_SCAN;
            ptr_nx   = ptr + PTR_W'(1);
          end
        end
      end
      FL_DONE: begin
        plru_clr = 1'b1;
        state_nx = FL_IDLE;
      end
      default: state_nx = FL_IDLE;
    endcase
  end

  assign blocked        = (state != FL_IDLE);
  assign flush_busy     = blocked;
  assign flush_done     = (state == FL_DONE);
  assign flush_wb_valid = (state == FL_WB);
  assign flush_wb_index = fl_set;
  assign flush_wb_way   = fl_way;
  assign flush_wb_tag   = tag_mem[fl_set][fl_way];
`else
  logic unused_flush;

  assign unused_flush   = flush_req ^ flush_wb_ack;
  assign fl_set         = '0;
  assign fl_way         = '0;
  assign clr_en         = 1'b0;
  assign plru_clr       = 1'b0;
  assign blocked        = 1'b0;
  assign flush_busy     = 1'b0;
  assign flush_done     = 1'b0;
  assign flush_wb_valid = 1'b0;
  assign flush_wb_index = '0;
  assign flush_wb_way   = '0;
  assign flush_wb_tag   = '0;
`endif

  // Array storage: fill, dirty-mark, PLRU promotion and walker clears.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      tag_mem   <= '{default: '0};
      valid_mem <= '{default: '0};
      dirty_mem <= '{default: '0};
      plru_mem  <= '{default: '0};
    end else begin
      if (fill_en) begin
        tag_mem[index][victim_way]   <= tag_in;
        valid_mem[index][victim_way] <= valid_in;
        dirty_mem[index][victim_way] <= dirty_in;
      end
      if (mark_en) dirty_mem[index][raw_hit_way] <= 1'b1;
      if (promote_en) plru_mem[index] <= plru_next;
      if (clr_en) begin
        valid_mem[fl_set][fl_way] <= 1'b0;
        dirty_mem[fl_set][fl_way] <= 1'b0;
      end
      if (plru_clr) plru_mem <= '{default: '0};
    end
  end

endmodule
